uart_hamming_receiver: RTL and testbench
========================================

# uart_hamming_receiver

Receive end of the Hamming(7,4)-over-UART link. Deserializes 8N1 frames from the serial line, Hamming(7,4)-decodes the 7-bit code in each byte with single-bit correction, and presents the recovered 4-bit nibble with a one-cycle valid pulse. Sits at the top level, fed from a dedicated input pin. Its nibble, valid and status outputs drive dedicated/debug outputs.

## Interface
- CLKS_PER_BIT, 16: clk cycles per UART bit; even, ≥4; must match the transmitter.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data_out  out  4  last decoded nibble; held until next valid_out.
- valid_out  out  1  one-cycle pulse: new data_out available.
- corrected  out  1  qualifies valid_out: a single-bit error was corrected.
- pad_err  out  1  qualifies valid_out: received byte bit 7 was 1 (ignored for decode).
- frame_err  out  1  one-cycle pulse: stop bit sampled low; no valid_out for that frame.
- rx_busy  out  1  high from accepted start edge until frame end (states START..STOP).

## Operation
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). Byte = {pad, c[6:0]}.
- Code layout: c[i] is Hamming position i+1. Parity: c[0], c[1], c[3]. Data: d[0]=c[2], d[1]=c[4], d[2]=c[5], d[3]=c[6]. Even parity.
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - syn = {s4,s2,s1}.
- syn≠0: flip c[syn-1] and set corrected. syn=0: no change.
- Double-bit errors are miscorrected silently. There is no detection.
- rx passes a 2-flop synchronizer. All logic uses the synchronized value rxs.
- FSM states:
  - IDLE: rxs falling edge (prev 1, now 1→0) → START, counter=0.
  - START: at count CLKS_PER_BIT/2−1, sample rxs.
    - 0 → DATA, bit index=0.
    - 1 → IDLE (glitch; no error flagged).
  - DATA: sample every CLKS_PER_BIT cycles into shift reg, LSB first. After bit 7 sample → STOP.
  - STOP: sample after CLKS_PER_BIT cycles (mid stop bit).
    - 1 → latch byte to decode register, → IDLE.
    - 0 → pulse frame_err, → WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then → IDLE. Prevents a break condition from retriggering.
- Decode register update: data_out, corrected and pad_err are registered together. valid_out pulses on the same cycle.
- Reset, including mid-frame: FSM→IDLE, counters/shift reg cleared, synchronizer flops set to 1. All outputs 0: data_out=0, valid_out=0, corrected=0, pad_err=0, frame_err=0, rx_busy=0.

## Timing
- Sampling starts 2 cycles after an rx edge, due to the synchronizer.
- valid_out asserts exactly 1 cycle after the stop-bit sample cycle.
- Stop sample to next possible start edge is ≥CLKS_PER_BIT/2 cycles. Back-to-back frames with no idle gap must be received without loss.
- corrected and pad_err are meaningful only while valid_out=1. Both are held with data_out otherwise.
- frame_err and valid_out are never high in the same cycle.
- Sampling point tolerance: ±(CLKS_PER_BIT/2−1) cycles of cumulative drift over 10 bits.

## Structure
- Shared package uart_hamming_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - Hamming position constants (parity/data indices);
  - default CLKS_PER_BIT.
- The transmit-side encoder imports the same position constants so the code layout stays single-sourced.
- One sub-module, hamming_decoder_74: purely combinational, c[6:0] → data[3:0], corrected. Instantiated once, feeding the decode register.

## Test plan
- Clean frame, byte 0x55 (nibble 0xB) → valid_out once, data_out=0xB, corrected=0, pad_err=0; valid_out 1 cycle after stop sample.
- Byte 0x45 (0x55 with c[4] flipped, syn=5) → data_out=0xB, corrected=1. Repeat for each of 7 single-bit flips of 0x7F → data_out=0xF, corrected=1.
- Byte 0xD5 (pad bit set) → data_out=0xB, pad_err=1, valid_out=1.
- Stop bit forced 0 on byte 0x00 → frame_err pulse, no valid_out, data_out keeps prior value. Hold rx low 3 bit times, then idle → no spurious frame; next clean frame decodes.
- rx low pulse of CLKS_PER_BIT/4 cycles → no valid_out/frame_err, rx_busy drops after half a bit. Back-to-back 0x00, 0x7F, 0x55 with zero gap → nibbles 0x0, 0xF, 0xB in order.
- rst_n asserted mid-DATA → all outputs 0 immediately. After release, a full clean frame 0x7F → data_out=0xF.

Source files
------------

// File: rtl/uart_hamming_pkg.sv
// Shared definitions for the Hamming(7,4)-over-UART link (transmitter and receiver).
// The code layout is defined only here, so both ends of the link stay consistent.
package uart_hamming_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // c[i] is Hamming position i+1; parity bits sit at the power-of-two positions
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef struct packed {
    logic [3:0] data;
    logic       corrected;
    logic       pad_err;
  } dec_t;

  // Syndrome {s4,s2,s1} equals the 1-based position of a single flipped bit
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
    logic s1, s2, s4;
    s1 = c[P1_POS] ^ c[D0_POS] ^ c[D1_POS] ^ c[D3_POS];
    s2 = c[P2_POS] ^ c[D0_POS] ^ c[D2_POS] ^ c[D3_POS];
    s4 = c[P4_POS] ^ c[D1_POS] ^ c[D2_POS] ^ c[D3_POS];
    return {s4, s2, s1};
  endfunction

endpackage

// File: rtl/uart_hamming_receiver_if.sv
// Serial input plus decoded-nibble/status outputs of the Hamming UART receiver.
// master = receiver side, slave = whatever drives rx and consumes the results.
interface uart_hamming_receiver_if;
  logic       rx;
  logic [3:0] data_out;
  logic       valid_out;
  logic       corrected;
  logic       pad_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    output data_out, valid_out, corrected, pad_err, frame_err, rx_busy
  );

  modport slave (
    output rx,
    input  data_out, valid_out, corrected, pad_err, frame_err, rx_busy
  );
endinterface

// File: rtl/hamming_decoder_74.sv
// Combinational Hamming(7,4) decoder with single-bit correction; zero latency.
// Double-bit errors are miscorrected without any indication.
module hamming_decoder_74
  import uart_hamming_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] data,
  output logic       corrected
);

  logic [2:0] syn;
  logic [6:0] fixed;

  always_comb begin
    syn   = hamming_syndrome(code);
    fixed = code;
    for (int i = 0; i < 7; i++) begin
      if (syn == 3'(i + 1)) fixed[i] = ~code[i];
    end
    corrected = (syn != 3'd0);
    data      = {fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};
  end

endmodule

// File: rtl/uart_hamming_receiver.sv
// 8N1 UART receiver feeding a Hamming(7,4) decoder; valid_out pulses one cycle after the
// mid-stop-bit sample. No backpressure: every decoded nibble is a single-cycle pulse.
module uart_hamming_receiver
  import uart_hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_hamming_receiver_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic          rx_meta, rxs, rxs_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          cnt_clr, shift_en, byte_ok, byte_bad;
  logic [3:0]    dec_data;
  logic          dec_corr;
  dec_t          dec_q;
  logic          valid_q, frame_err_q;

  // rx is asynchronous; idle-high reset values keep a reset from looking like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rxs_q && !rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_clr = 1'b1;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            byte_ok = 1'b1;
            state_d = IDLE;
          end else begin
            byte_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      // A held-low line (break) must return high before another start is accepted
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
      if (state_q != DATA) bit_q <= '0;
      else if (shift_en)   bit_q <= bit_q + 1'b1;
      if (shift_en) shreg_q <= {rxs, shreg_q[7:1]};
    end
  end

  hamming_decoder_74 u_dec (
    .code      (shreg_q[6:0]),
    .data      (dec_data),
    .corrected (dec_corr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= byte_ok;
      frame_err_q <= byte_bad;
      if (byte_ok) dec_q <= '{data: dec_data, corrected: dec_corr, pad_err: shreg_q[7]};
    end
  end

  assign bus.data_out  = dec_q.data;
  assign bus.corrected = dec_q.corrected;
  assign bus.pad_err   = dec_q.pad_err;
  assign bus.valid_out = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_hamming_receiver.sv
// Directed bench for uart_hamming_receiver: clean/corrected/padded frames, framing error,
// start glitch, back-to-back frames and asynchronous reset mid-frame.
module tb_uart_hamming_receiver;

  localparam int CPB = 16;
  // start drive -> valid visible: 2 sync + CPB/2 + 9*CPB + 1 register
  localparam int LAT = 155;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_hamming_receiver_if bus ();

  uart_hamming_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_start = 0;
  int last_vcyc = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic [31:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out) begin
      got_q.push_back({26'b0, bus.data_out, bus.corrected, bus.pad_err});
      last_vcyc = cyc;
    end
    if (bus.frame_err) fe_cnt++;
    if (bus.frame_err && bus.valid_out) both_cnt++;
  end

  function automatic logic [31:0] ent(input logic [3:0] nib, input logic c, input logic p);
    return {26'b0, nib, c, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic expect_one(input string tag, input logic [31:0] exp);
    chk({tag, "_cnt"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk(tag, got_q.pop_front(), exp);
    got_q.delete();
  endtask

  // Called on a negedge; returns on the negedge that ends the stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    tx_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(bus.data_out),  32'd0);
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_corr"},  32'(bus.corrected), 32'd0);
    chk({tag, "_pad"},   32'(bus.pad_err),   32'd0);
    chk({tag, "_fe"},    32'(bus.frame_err), 32'd0);
    chk({tag, "_busy"},  32'(bus.rx_busy),   32'd0);
  endtask

  initial begin
    int fe0;
    logic [7:0] b;
    bus.rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    idle(5);

    // clean frame and latency
    send_byte(8'h55, 1'b1);
    idle(20);
    chk("lat55", 32'(last_vcyc - tx_start), 32'(LAT));
    expect_one("b55", ent(4'hB, 1'b0, 1'b0));

    send_byte(8'h45, 1'b1);
    idle(20);
    expect_one("b45", ent(4'hB, 1'b1, 1'b0));

    for (int i = 0; i < 7; i++) begin
      b = 8'h7F ^ (8'h01 << i);
      send_byte(b, 1'b1);
      idle(20);
      expect_one($sformatf("flip%0d", i), ent(4'hF, 1'b1, 1'b0));
    end

    send_byte(8'hD5, 1'b1);
    idle(20);
    expect_one("bD5", ent(4'hB, 1'b0, 1'b1));

    // framing error followed by a break
    fe0 = fe_cnt;
    send_byte(8'h00, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    idle(40);
    chk("fe_cnt", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_noval", 32'(got_q.size()), 32'd0);
    chk("fe_hold", 32'(bus.data_out), 32'hB);
    send_byte(8'h7F, 1'b1);
    idle(20);
    expect_one("after_fe", ent(4'hF, 1'b0, 1'b0));
    chk("fe_cnt2", 32'(fe_cnt - fe0), 32'd1);

    // short start glitch
    fe0 = fe_cnt;
    bus.rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("gl_busy", 32'(bus.rx_busy), 32'd1);
    repeat (6) @(negedge clk);
    chk("gl_idle", 32'(bus.rx_busy), 32'd0);
    idle(30);
    chk("gl_noval", 32'(got_q.size()), 32'd0);
    chk("gl_nofe", 32'(fe_cnt - fe0), 32'd0);

    // back-to-back frames, no idle gap
    send_byte(8'h00, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(20);
    chk("b2b_cnt", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("b2b0", got_q[0], ent(4'h0, 1'b0, 1'b0));
      chk("b2b1", got_q[1], ent(4'hF, 1'b0, 1'b0));
      chk("b2b2", got_q[2], ent(4'hB, 1'b0, 1'b0));
    end
    got_q.delete();

    // asynchronous reset in the middle of the data bits
    bus.rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.rx_busy), 32'd1);
    chk("pre_rst_data", 32'(bus.data_out), 32'hB);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_byte(8'h7F, 1'b1);
    idle(20);
    expect_one("post_rst", ent(4'hF, 1'b0, 1'b0));
    chk("post_rst_data", 32'(bus.data_out), 32'hF);

    chk("val_fe_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
